fuzzy_entrada_cond: RTL and testbench
=====================================

FUZZY_ENTRADA_COND -- requirements
Module: fuzzy_entrada_cond

Interface
REQ-001 Parameter HOLD_CYCLES, default 8: number of cycles the fuzzy inputs are held stable after each update; legal range 1..255.
REQ-002 Parameter DE_SHIFT, default 1: arithmetic right shift applied to delta-error before offset; legal range 0..3.
REQ-003 clk_0  input  1  single clock; all state updates on the rising edge.
REQ-004 Srst  input  1  reset, synchronous, active-high.
REQ-005 setpoint  input  8  unsigned reference value.
REQ-006 medida  input  8  unsigned measured plant value.
REQ-007 amostra_valid  input  1  new sample offered on setpoint/medida.
REQ-008 amostra_ready  output  1  block accepts a sample this cycle.
REQ-009 Entrada_01  output  8  offset-coded error, range 1..254, 128 = zero error.
REQ-010 Entrada_02  output  8  offset-coded delta-error, range 1..254, 128 = zero change.
REQ-011 saida_valid  output  1  one-cycle pulse when Entrada_01/Entrada_02 take new values.
REQ-012 contador_amostras  output  8  count of accepted samples, wraps 255->0.

Function
REQ-013 FSM states IDLE, CALC, HOLD; amostra_ready = 1 only in IDLE.
REQ-014 IDLE: amostra_valid=1 at a rising edge captures setpoint and medida, increments contador_amostras, moves to CALC.
REQ-015 CALC lasts exactly one cycle; at its closing edge Entrada_01, Entrada_02 are registered, saida_valid is set to 1, and FSM moves to HOLD.
REQ-016 Latency: outputs and saida_valid change on the second rising edge after the accepting edge.
REQ-017 saida_valid is high for exactly the first cycle of HOLD, low otherwise.
REQ-018 HOLD lasts exactly HOLD_CYCLES cycles, then returns to IDLE; Entrada_01/02 hold their values until the next CALC.
REQ-019 amostra_valid outside IDLE is ignored: no capture, no count change.
REQ-020 Error e = setpoint - medida_f, signed 10-bit (range -255..255); Entrada_01 = clamp(128 + e, 1, 254).
REQ-021 Delta d = e - e_prev, signed 10-bit (range -510..510); Entrada_02 = clamp(128 + (d >>> DE_SHIFT), 1, 254); all intermediates wide enough that no overflow occurs before clamping.
REQ-022 e_prev is updated with e at each CALC; on the first sample after reset e_prev is taken equal to e, so Entrada_02 = 128.
REQ-023 Outputs never take values 0 or 255.

Reset
REQ-024 Srst=1 at a rising edge, in any state including CALC and HOLD, forces IDLE, Entrada_01=128, Entrada_02=128, saida_valid=0, amostra_ready=1, contador_amostras=0, clears the first-sample flag.
REQ-025 Srst has priority over amostra_valid in the same cycle; no sample is captured.

Configuration
REQ-026 Macro COND_FILTRO_EN defined: medida_f = (medida + medida_prev) >> 1 (9-bit sum, floor), medida_prev updated at each capture; first sample after reset uses medida_prev = medida.
REQ-027 Macro COND_FILTRO_EN undefined: medida_f = captured medida; no filter register is built.

Verification
REQ-028 Srst high 3 cycles -> Entrada_01=128, Entrada_02=128, saida_valid=0, amostra_ready=1, contador_amostras=0.
REQ-029 First sample setpoint=100, medida=60 -> two edges later Entrada_01=168, Entrada_02=128, saida_valid pulse 1 cycle, contador_amostras=1.
REQ-030 Samples (128,128) then (128,108), DE_SHIFT=1, no filter -> second update Entrada_01=148, Entrada_02=138.
REQ-031 Samples (255,0) then (0,255), no filter -> first Entrada_01=254; second Entrada_01=1, Entrada_02=1.
REQ-032 amostra_valid held high continuously, HOLD_CYCLES=8 -> amostra_ready low 9 cycles per sample (CALC+HOLD), one capture per 10 cycles, no extra count; Srst asserted mid-HOLD -> outputs 128, IDLE next cycle.
REQ-033 COND_FILTRO_EN defined, samples (100,100) then (100,60) -> second update Entrada_01=148, Entrada_02=138.

Source files
------------

// File: rtl/fuzzy_entrada_cond.sv
// Purpose : fuzzy-controller input conditioner. It turns a (setpoint, medida)
//           sample into offset-coded error and delta-error values in 1..254.
// Latency : outputs and saida_valid update on the 2nd rising edge after the accepting edge.
// Backpr. : amostra_ready is high only in IDLE. After each capture the block
//           is busy for 1 + HOLD_CYCLES cycles and ignores amostra_valid.
//
// Ports
//   clk_0             single clock, rising edge
//   Srst              synchronous active-high reset
//   setpoint, medida  unsigned 8-bit reference and measured plant value
//   amostra_valid     a sample is offered on setpoint/medida
//   amostra_ready     block accepts a sample this cycle (registered, high only in IDLE)
//   Entrada_01        clamp(128 + e, 1, 254), where e = setpoint - medida_f
//   Entrada_02        clamp(128 + ((e - e_prev) >>> DE_SHIFT), 1, 254)
//   saida_valid       one-cycle pulse when Entrada_01/02 take new values
//   contador_amostras count of accepted samples, wraps 255 -> 0
//
// Optional feature: define COND_FILTRO_EN to enable a 2-tap average on
// medida: medida_f = (medida + medida_prev) >> 1.
module fuzzy_entrada_cond #(
    parameter int unsigned HOLD_CYCLES = 8,   // 1..255
    parameter int unsigned DE_SHIFT    = 1    // 0..3
) (
    input  logic       clk_0,
    input  logic       Srst,
    input  logic [7:0] setpoint,
    input  logic [7:0] medida,
    input  logic       amostra_valid,
    output logic       amostra_ready,
    output logic [7:0] Entrada_01,
    output logic [7:0] Entrada_02,
    output logic       saida_valid,
    output logic [7:0] contador_amostras
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] ZERO_CODE = 8'd128;

    state_t            state;
    logic [7:0]        hold_cnt;
    logic [7:0]        sp_q;        // captured setpoint
    logic [7:0]        mf_q;        // captured (possibly filtered) medida
    logic signed [9:0] e_prev;
    logic              has_prev;    // cleared by reset; set once a sample has gone through CALC

    // Measurement path: either the raw sample or the 2-tap average.
    logic [7:0] medida_f;
`ifdef COND_FILTRO_EN
    logic [7:0] medida_prev;
    logic [8:0] medida_sum;

    assign medida_sum = {1'b0, medida} + {1'b0, medida_prev};
    // On the first sample after reset there is no history, so medida is
    // averaged with itself. That gives medida.
    assign medida_f   = has_prev ? 8'(medida_sum >> 1) : medida;

    always_ff @(posedge clk_0) begin
        if (Srst) begin
            medida_prev <= 8'd0;
        end else if (state == IDLE && amostra_valid) begin
            medida_prev <= medida;
        end
    end
`else
    assign medida_f = medida;
`endif

    // Error and delta-error arithmetic. The widths are chosen so that no
    // intermediate value can overflow: e is in -255..255 and fits in 10 bits
    // signed. d is in -510..510. It is kept in 11 bits so the subtraction
    // has headroom.
    logic signed [9:0]  err;
    logic signed [10:0] dlt;
    logic signed [10:0] dlt_sh;

    assign err    = $signed({2'b00, sp_q}) - $signed({2'b00, mf_q});
    assign dlt    = has_prev ? ($signed({err[9], err}) - $signed({e_prev[9], e_prev}))
                             : 11'sd0;
    assign dlt_sh = dlt >>> DE_SHIFT;

    // Add the 128 offset and saturate into 1..254. The codes 0 and 255 are
    // never produced.
    function automatic logic [7:0] clamp_code(input logic signed [11:0] v);
        logic signed [11:0] s;
        s = v + 12'sd128;
        if (s < 12'sd1) begin
            return 8'd1;
        end else if (s > 12'sd254) begin
            return 8'd254;
        end else begin
            return s[7:0];
        end
    endfunction

    always_ff @(posedge clk_0) begin
        if (Srst) begin
            state             <= IDLE;
            hold_cnt          <= 8'd0;
            sp_q              <= 8'd0;
            mf_q              <= 8'd0;
            e_prev            <= 10'sd0;
            has_prev          <= 1'b0;
            Entrada_01        <= ZERO_CODE;
            Entrada_02        <= ZERO_CODE;
            saida_valid       <= 1'b0;
            amostra_ready     <= 1'b1;
            contador_amostras <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    saida_valid <= 1'b0;
                    if (amostra_valid) begin
                        sp_q              <= setpoint;
                        mf_q              <= medida_f;
                        contador_amostras <= contador_amostras + 8'd1;
                        amostra_ready     <= 1'b0;
                        state             <= CALC;
                    end
                end

                CALC: begin
                    Entrada_01  <= clamp_code({{2{err[9]}}, err});
                    Entrada_02  <= clamp_code({dlt_sh[10], dlt_sh});
                    e_prev      <= err;
                    has_prev    <= 1'b1;
                    saida_valid <= 1'b1;
                    hold_cnt    <= HOLD_LOAD;
                    state       <= HOLD;
                end

                HOLD: begin
                    // saida_valid goes high only in the first HOLD cycle.
                    saida_valid <= 1'b0;
                    if (hold_cnt == 8'd0) begin
                        amostra_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end

                default: begin
                    saida_valid   <= 1'b0;
                    amostra_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzy_entrada_cond.sv
// Purpose : self-checking bench for fuzzy_entrada_cond. It uses directed
//           vectors plus random samples checked against an arithmetic model.
// Latency : checks the 2-edge output latency and the busy window of 1+HOLD_CYCLES cycles.
// Backpr. : drives amostra_valid randomly while the block is busy to show that the input is ignored.
module tb_fuzzy_entrada_cond;

    localparam int HOLD     = 8;
    localparam int DE_SHIFT = 1;

    logic       clk_0 = 1'b0;
    logic       Srst = 1'b1;
    logic [7:0] setpoint = 8'd0;
    logic [7:0] medida = 8'd0;
    logic       amostra_valid = 1'b0;
    logic       amostra_ready;
    logic [7:0] Entrada_01;
    logic [7:0] Entrada_02;
    logic       saida_valid;
    logic [7:0] contador_amostras;

    int vectors = 0;
    int errors  = 0;

    // Reference-model state
    int m_cnt;
    int m_eprev;
    int m_mprev;
    bit m_first;
    int last_e1;
    int last_e2;

    fuzzy_entrada_cond #(
        .HOLD_CYCLES(HOLD),
        .DE_SHIFT   (DE_SHIFT)
    ) dut (
        .clk_0            (clk_0),
        .Srst             (Srst),
        .setpoint         (setpoint),
        .medida           (medida),
        .amostra_valid    (amostra_valid),
        .amostra_ready    (amostra_ready),
        .Entrada_01       (Entrada_01),
        .Entrada_02       (Entrada_02),
        .saida_valid      (saida_valid),
        .contador_amostras(contador_amostras)
    );

    always #5 clk_0 = ~clk_0;

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < 1)   return 1;
        if (v > 254) return 254;
        return v;
    endfunction

    // Floor division by a positive divisor. Negative numbers round toward
    // minus infinity.
    function automatic int floordiv(input int n, input int q);
        if (n >= 0) return n / q;
        return -((-n + q - 1) / q);
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_eprev = 0;
        m_mprev = 0;
        m_first = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_e1"},  32'(Entrada_01), 128);
        chk({tag, "_e2"},  32'(Entrada_02), 128);
        chk({tag, "_vld"}, 32'(saida_valid), 0);
        chk({tag, "_rdy"}, 32'(amostra_ready), 1);
        chk({tag, "_cnt"}, 32'(contador_amostras), 0);
    endtask

    task automatic do_reset(input int cycles);
        Srst          = 1'b1;
        amostra_valid = 1'b1;   // reset must win over a pending sample
        setpoint      = 8'd200;
        medida        = 8'd10;
        for (int i = 0; i < cycles; i++) begin
            tick();
            check_reset_state("rst");
        end
        Srst          = 1'b0;
        amostra_valid = 1'b0;
        model_reset();
    endtask

    // Called with the block in IDLE, #1 after an edge. It offers one sample
    // and follows it through CALC and HOLD until the block is back in IDLE.
    task automatic do_sample(input int sp, input int md, input bit noisy);
        int mf, e, d, x1, x2;
        chk("rdy_idle", 32'(amostra_ready), 1);
        setpoint      = 8'(sp);
        medida        = 8'(md);
        amostra_valid = 1'b1;
        tick();

`ifdef COND_FILTRO_EN
        mf      = m_first ? md : (md + m_mprev) / 2;
        m_mprev = md;
`else
        mf = md;
`endif
        e       = sp - mf;
        d       = m_first ? 0 : e - m_eprev;
        m_eprev = e;
        m_first = 1'b0;
        m_cnt   = (m_cnt + 1) % 256;
        x1      = clampi(128 + e);
        x2      = clampi(128 + floordiv(d, 1 << DE_SHIFT));

        amostra_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        setpoint      = 8'($urandom);
        medida        = 8'($urandom);
        chk("rdy_calc", 32'(amostra_ready), 0);
        chk("vld_calc", 32'(saida_valid), 0);
        chk("cnt_calc", 32'(contador_amostras), 32'(m_cnt));
        tick();

        chk("vld_pulse", 32'(saida_valid), 1);
        chk("e1", 32'(Entrada_01), 32'(x1));
        chk("e2", 32'(Entrada_02), 32'(x2));
        for (int i = 1; i < HOLD; i++) begin
            amostra_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            chk("rdy_hold", 32'(amostra_ready), 0);
            chk("vld_hold", 32'(saida_valid), 0);
            chk("e1_hold", 32'(Entrada_01), 32'(x1));
            chk("e2_hold", 32'(Entrada_02), 32'(x2));
            chk("cnt_hold", 32'(contador_amostras), 32'(m_cnt));
        end
        amostra_valid = 1'b0;
        tick();
        chk("rdy_back", 32'(amostra_ready), 1);
        chk("vld_back", 32'(saida_valid), 0);
        chk("cnt_back", 32'(contador_amostras), 32'(m_cnt));
        last_e1 = x1;
        last_e2 = x2;
    endtask

    initial begin
        int rdy_hi;
        int c0;

        model_reset();

        // Reset held high for 3 cycles, with a sample pending on the inputs.
        do_reset(3);
        check_reset_state("post_rst");
        tick();
        chk("no_capture_after_rst", 32'(contador_amostras), 0);

        // First sample, (100,60)
        do_sample(100, 60, 1'b0);
`ifndef COND_FILTRO_EN
        chk("dir_first_e1", 32'(last_e1), 168);
        chk("dir_first_e2", 32'(last_e2), 128);
`endif
        chk("dir_first_cnt", 32'(contador_amostras), 1);

        // (128,128) then (128,108)
        do_reset(1);
        do_sample(128, 128, 1'b0);
        do_sample(128, 108, 1'b0);
`ifndef COND_FILTRO_EN
        chk("dir_delta_e1", 32'(last_e1), 148);
        chk("dir_delta_e2", 32'(last_e2), 138);
`endif

        // Saturation at both ends: (255,0) then (0,255)
        do_reset(1);
        do_sample(255, 0, 1'b0);
`ifndef COND_FILTRO_EN
        chk("dir_sat_hi_e1", 32'(last_e1), 254);
`endif
        do_sample(0, 255, 1'b0);
`ifndef COND_FILTRO_EN
        chk("dir_sat_lo_e1", 32'(last_e1), 1);
        chk("dir_sat_lo_e2", 32'(last_e2), 1);
`endif

`ifdef COND_FILTRO_EN
        // Filtered path: (100,100) then (100,60)
        do_reset(1);
        do_sample(100, 100, 1'b0);
        do_sample(100, 60, 1'b0);
        chk("dir_filt_e1", 32'(last_e1), 148);
        chk("dir_filt_e2", 32'(last_e2), 138);
`endif

        // amostra_valid held high: one capture every 1 + 1 + HOLD cycles
        do_reset(1);
        c0            = 0;
        rdy_hi        = 0;
        setpoint      = 8'd90;
        medida        = 8'd80;
        amostra_valid = 1'b1;
        for (int i = 0; i < 2 * (HOLD + 2); i++) begin
            if (amostra_ready) rdy_hi++;
            tick();
        end
        chk("cont_rdy_cycles", 32'(rdy_hi), 2);
        chk("cont_count", 32'(contador_amostras), 32'(c0 + 2));
        chk("cont_rdy_again", 32'(amostra_ready), 1);

        // Reset in the middle of HOLD
        tick();                 // capture #3, block now in CALC
        tick();                 // first HOLD cycle
        tick();
        Srst          = 1'b1;
        amostra_valid = 1'b0;
        tick();
        Srst = 1'b0;
        check_reset_state("mid_hold_rst");
        model_reset();

        // Random samples with noise on amostra_valid while the block is busy.
        // The run is long enough to wrap contador_amostras.
        for (int n = 0; n < 262; n++) begin
            do_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Overall time bound
    initial begin
        #2000000;
        $display("FAIL timeout: observed no completion, expected $finish");
        $fatal(1, "timeout");
    end

endmodule
